axis_alu_pipe: RTL and testbench

//  Multi-channel AXI-Stream ALU for the KAN datapath, successor to the fixed-op single-register ALU.

---
 rtl/axis_alu_pipe.sv | 203 ++++++++++++++++++++
 tb/tb_axis_alu_pipe.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_alu_pipe.sv
// axis_alu_pipe: per-channel AXI-Stream ALU with opcode per beat,
// configurable pipeline depth, fixed-point round/saturate and a MAC.
// Ports: clk, rst (sync, active-high); s_axis_{op0,op1,opcode,tvalid,
// tlast,tuser} in, s_axis_tready out; m_axis_{tdata,tvalid,tlast,tuser,
// tsat,terr} out, m_axis_tready in. All buses are CHANNELS lanes wide.
module axis_alu_pipe #(
  parameter int OP0_WIDTH   = 16,
  parameter int OP1_WIDTH   = 16,
  parameter int RSLT_WIDTH  = 16,
  parameter int ACC_WIDTH   = 40,
  parameter int CHANNELS    = 1,
  parameter int PIPE_STAGES = 2,
  parameter int FRAC_SHIFT  = 0,
  parameter int LAST_ENABLE = 1,
  parameter int USER_ENABLE = 1,
  parameter int USER_WIDTH  = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CHANNELS*OP0_WIDTH-1:0]  s_axis_op0,
  input  logic [CHANNELS*OP1_WIDTH-1:0]  s_axis_op1,
  input  logic [CHANNELS*3-1:0]          s_axis_opcode,
  input  logic [CHANNELS-1:0]            s_axis_tvalid,
  output logic [CHANNELS-1:0]            s_axis_tready,
  input  logic [CHANNELS-1:0]            s_axis_tlast,
  input  logic [CHANNELS*USER_WIDTH-1:0] s_axis_tuser,
  output logic [CHANNELS*RSLT_WIDTH-1:0] m_axis_tdata,
  output logic [CHANNELS-1:0]            m_axis_tvalid,
  input  logic [CHANNELS-1:0]            m_axis_tready,
  output logic [CHANNELS-1:0]            m_axis_tlast,
  output logic [CHANNELS*USER_WIDTH-1:0] m_axis_tuser,
  output logic [CHANNELS-1:0]            m_axis_tsat,
  output logic [CHANNELS-1:0]            m_axis_terr
);

  localparam int NS = (PIPE_STAGES < 1) ? 1 : PIPE_STAGES;
  // Internal width holds any full-precision result plus rounding.
  localparam int EW = ACC_WIDTH + 1;
  localparam int RS = (FRAC_SHIFT > 0) ? FRAC_SHIFT - 1 : 0;
  localparam logic signed [EW-1:0] RND =
    (FRAC_SHIFT > 0) ? (EW'(1) << RS) : '0;
  localparam logic signed [EW-1:0] SMAX =
    {{(EW-RSLT_WIDTH+1){1'b0}}, {(RSLT_WIDTH-1){1'b1}}};
  localparam logic signed [EW-1:0] SMIN =
    {{(EW-RSLT_WIDTH+1){1'b1}}, {(RSLT_WIDTH-1){1'b0}}};

  if (PIPE_STAGES < 1) begin : g_bad_cfg
    $error("axis_alu_pipe: PIPE_STAGES must be >= 1");
  end

  // Input side stays closed for one cycle after reset drops.
  logic rst_dly_q, rst_dly_d;
  logic quiet;

  always_comb rst_dly_d = rst;

  always_ff @(posedge clk) begin
    rst_dly_q <= rst_dly_d;
  end

  assign quiet = rst || rst_dly_q;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic signed [OP0_WIDTH-1:0] a;
    logic signed [OP1_WIDTH-1:0] b;
    logic [2:0]                  op;
    logic [USER_WIDTH-1:0]       u_in;

    logic [NS-1:0]                 v_q, v_d;
    logic [NS-1:0][RSLT_WIDTH-1:0] dat_q, dat_d;
    logic [NS-1:0]                 lst_q, lst_d;
    logic [NS-1:0]                 sat_q, sat_d;
    logic [NS-1:0]                 err_q, err_d;
    logic [NS-1:0][USER_WIDTH-1:0] usr_q, usr_d;

    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                        clr_q, clr_d;

    logic adv, rdy, take;
    logic signed [EW-1:0] ax, bx, pre, rnd_in, rnd_out;
    logic signed [ACC_WIDTH-1:0] prod, acc_base, acc_new;
    logic use_rnd;
    logic [RSLT_WIDTH-1:0] res;
    logic res_sat, res_err;

    assign a    = s_axis_op0[c*OP0_WIDTH +: OP0_WIDTH];
    assign b    = s_axis_op1[c*OP1_WIDTH +: OP1_WIDTH];
    assign op   = s_axis_opcode[c*3 +: 3];
    assign u_in = s_axis_tuser[c*USER_WIDTH +: USER_WIDTH];

    assign adv  = !v_q[NS-1] || m_axis_tready[c];
    assign rdy  = adv && !quiet;
    assign take = s_axis_tvalid[c] && rdy;
    assign s_axis_tready[c] = rdy;

    always_comb begin : p_alu
      ax       = EW'(a);
      bx       = EW'(b);
      prod     = ACC_WIDTH'(ax * bx);
      acc_base = clr_q ? '0 : acc_q;
      acc_new  = acc_base + prod;
      pre      = '0;
      use_rnd  = 1'b0;
      res_err  = 1'b0;
      unique case (op)
        3'd0: pre = ax + bx;
        3'd1: pre = ax - bx;
        3'd2: begin
          pre     = EW'(prod);
          use_rnd = 1'b1;
        end
        3'd3: pre = ax[EW-1] ? -ax : ax;
        3'd4: pre = (bx > ax) ? bx : ax;
        3'd5: pre = (bx < ax) ? bx : ax;
        3'd6: begin
          pre     = EW'(acc_new);
          use_rnd = 1'b1;
        end
        default: res_err = 1'b1;
      endcase
      rnd_in  = pre + RND;
      rnd_out = use_rnd ? (rnd_in >>> FRAC_SHIFT) : pre;
      res_sat = 1'b0;
      if (rnd_out > SMAX) begin
        res     = SMAX[RSLT_WIDTH-1:0];
        res_sat = 1'b1;
      end else if (rnd_out < SMIN) begin
        res     = SMIN[RSLT_WIDTH-1:0];
        res_sat = 1'b1;
      end else begin
        res = rnd_out[RSLT_WIDTH-1:0];
      end
    end

    always_comb begin : p_acc
      acc_d = acc_q;
      clr_d = clr_q;
      if (take && op == 3'd6) begin
        acc_d = acc_new;
        clr_d = (LAST_ENABLE != 0) && s_axis_tlast[c];
      end
    end

    // Whole pipe shifts together; a stalled output freezes it.
    always_comb begin : p_pipe
      v_d   = v_q;
      dat_d = dat_q;
      lst_d = lst_q;
      sat_d = sat_q;
      err_d = err_q;
      usr_d = usr_q;
      if (adv) begin
        for (int i = NS - 1; i > 0; i--) begin
          v_d[i]   = v_q[i-1];
          dat_d[i] = dat_q[i-1];
          lst_d[i] = lst_q[i-1];
          sat_d[i] = sat_q[i-1];
          err_d[i] = err_q[i-1];
          usr_d[i] = usr_q[i-1];
        end
        v_d[0]   = take;
        dat_d[0] = take ? res : '0;
        lst_d[0] = take && s_axis_tlast[c];
        sat_d[0] = take && res_sat;
        err_d[0] = take && res_err;
        usr_d[0] = take ? u_in : '0;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q   <= '0;
        dat_q <= '0;
        lst_q <= '0;
        sat_q <= '0;
        err_q <= '0;
        usr_q <= '0;
        acc_q <= '0;
        clr_q <= 1'b1;
      end else begin
        v_q   <= v_d;
        dat_q <= dat_d;
        lst_q <= lst_d;
        sat_q <= sat_d;
        err_q <= err_d;
        usr_q <= usr_d;
        acc_q <= acc_d;
        clr_q <= clr_d;
      end
    end

    assign m_axis_tvalid[c] = v_q[NS-1] && !quiet;
    assign m_axis_tdata[c*RSLT_WIDTH +: RSLT_WIDTH] =
      quiet ? '0 : dat_q[NS-1];
    assign m_axis_tlast[c] = !quiet &&
      ((LAST_ENABLE != 0) ? lst_q[NS-1] : 1'b1);
    assign m_axis_tuser[c*USER_WIDTH +: USER_WIDTH] =
      (quiet || USER_ENABLE == 0) ? '0 : usr_q[NS-1];
    assign m_axis_tsat[c] = !quiet && sat_q[NS-1];
    assign m_axis_terr[c] = !quiet && err_q[NS-1];
  end

endmodule

// File: tb/tb_axis_alu_pipe.sv
// tb_axis_alu_pipe: scoreboard bench for axis_alu_pipe, 2 channels,
// 3 stages, FRAC_SHIFT=8; directed vectors with hand-computed results.
module tb_axis_alu_pipe;
  localparam int CH = 2;
  localparam int PS = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [CH*16-1:0] s_op0, s_op1, m_data;
  logic [CH*3-1:0]  s_opc;
  logic [CH-1:0] s_valid, s_ready, s_last, s_user;
  logic [CH-1:0] m_valid, m_last, m_user, m_sat, m_err;
  logic [CH-1:0] m_ready = '0;
  logic [CH-1:0] rdy_fix = '0;
  bit rnd_mode = 1'b0;

  logic [15:0] op0_a [CH];
  logic [15:0] op1_a [CH];
  logic [2:0]  opc_a [CH];
  logic        val_a [CH];
  logic        last_a [CH];
  logic        user_a [CH];

  always_comb begin
    for (int i = 0; i < CH; i++) begin
      s_op0[i*16 +: 16] = op0_a[i];
      s_op1[i*16 +: 16] = op1_a[i];
      s_opc[i*3 +: 3]   = opc_a[i];
      s_valid[i] = val_a[i];
      s_last[i]  = last_a[i];
      s_user[i]  = user_a[i];
    end
  end

  axis_alu_pipe #(
    .CHANNELS(CH), .PIPE_STAGES(PS), .FRAC_SHIFT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_op0(s_op0), .s_axis_op1(s_op1),
    .s_axis_opcode(s_opc), .s_axis_tvalid(s_valid),
    .s_axis_tready(s_ready), .s_axis_tlast(s_last),
    .s_axis_tuser(s_user), .m_axis_tdata(m_data),
    .m_axis_tvalid(m_valid), .m_axis_tready(m_ready),
    .m_axis_tlast(m_last), .m_axis_tuser(m_user),
    .m_axis_tsat(m_sat), .m_axis_terr(m_err)
  );

  typedef struct packed {
    logic [15:0] d;
    logic l, u, s, e;
    logic [31:0] cyc;
    logic lat;
  } exp_t;

  typedef struct packed {
    logic [2:0] op;
    logic [15:0] a, b;
    logic l;
    logic [15:0] x;
    logic s, e;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [31:0] cyc = '0;
  exp_t q0[$];
  exp_t q1[$];
  logic [19:0] hold_val [CH];
  bit hold_v [CH];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    for (int i = 0; i < CH; i++)
      m_ready[i] = rnd_mode ? ($urandom_range(0, 99) >= 30) : rdy_fix[i];
  end

  always @(negedge clk) begin
    for (int ch = 0; ch < CH; ch++) begin
      logic [19:0] obs;
      exp_t e;
      bit empty;
      obs = {m_data[ch*16 +: 16], m_last[ch], m_user[ch],
             m_sat[ch], m_err[ch]};
      if (m_valid[ch] && m_ready[ch]) begin
        hold_v[ch] = 1'b0;
        empty = (ch == 0) ? (q0.size() == 0) : (q1.size() == 0);
        checks++;
        if (empty) begin
          errors++;
          $display("FAIL unexpected_beat ch%0d got %h", ch, obs);
        end else begin
          if (ch == 0) e = q0.pop_front();
          else e = q1.pop_front();
          if (obs !== {e.d, e.l, e.u, e.s, e.e}) begin
            errors++;
            $display("FAIL beat ch%0d got {d,l,u,s,e}=%h want %h",
                     ch, obs, {e.d, e.l, e.u, e.s, e.e});
          end
          if (e.lat) begin
            checks++;
            if (cyc - e.cyc != PS) begin
              errors++;
              $display("FAIL latency ch%0d got %0d want %0d",
                       ch, cyc - e.cyc, PS);
            end
          end
        end
      end else if (m_valid[ch]) begin
        if (hold_v[ch]) begin
          checks++;
          if (obs !== hold_val[ch]) begin
            errors++;
            $display("FAIL stall_hold ch%0d got %h want %h",
                     ch, obs, hold_val[ch]);
          end
        end
        hold_v[ch] = 1'b1;
        hold_val[ch] = obs;
      end else begin
        hold_v[ch] = 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic send(input int ch, input vec_t v, input bit lat);
    exp_t e;
    bit ok = 1'b0;
    int waited = 0;
    op0_a[ch]  = v.a;
    op1_a[ch]  = v.b;
    opc_a[ch]  = v.op;
    last_a[ch] = v.l;
    user_a[ch] = v.a[0] ^ ch[0];
    val_a[ch]  = 1'b1;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk);
      if (s_ready[ch]) ok = 1'b1;
      else waited++;
    end
    if (ok) begin
      e.d = v.x; e.l = v.l; e.u = v.a[0] ^ ch[0];
      e.s = v.s; e.e = v.e; e.cyc = cyc; e.lat = lat;
      if (ch == 0) q0.push_back(e);
      else q1.push_back(e);
      if (lat) chk("t1_no_bubble_wait", waited, 0);
    end else begin
      checks++;
      errors++;
      $display("FAIL accept_timeout ch%0d got no tready want 1", ch);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int ch);
    val_a[ch]  = 1'b0;
    last_a[ch] = 1'b0;
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int n = 0; n < 500 && !done; n++) begin
      @(negedge clk);
      if (q0.size() == 0 && q1.size() == 0) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout got %0d/%0d pending want 0",
               q0.size(), q1.size());
    end
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [2:0] op,
      input logic [15:0] a, b, input logic l,
      input logic [15:0] x, input logic s, e);
    vec_t v;
    v = {op, a, b, l, x, s, e};
    return v;
  endfunction

  vec_t tbl [14];

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < CH; i++) begin
      op0_a[i] = '0; op1_a[i] = '0; opc_a[i] = '0;
      val_a[i] = 1'b0; last_a[i] = 1'b0; user_a[i] = 1'b0;
    end
    tbl[0]  = mk(3'd0, 16'd5, 16'd7, 0, 16'd12, 0, 0);
    tbl[1]  = mk(3'd1, 16'd5, 16'd7, 0, -16'sd2, 0, 0);
    tbl[2]  = mk(3'd2, 16'd256, 16'd512, 0, 16'd512, 0, 0);
    tbl[3]  = mk(3'd3, -16'sd9, 16'd0, 0, 16'd9, 0, 0);
    tbl[4]  = mk(3'd4, -16'sd4, 16'd3, 0, 16'd3, 0, 0);
    tbl[5]  = mk(3'd5, -16'sd4, 16'd3, 0, -16'sd4, 0, 0);
    tbl[6]  = mk(3'd7, 16'd11, 16'd22, 0, 16'd0, 0, 1);
    tbl[7]  = mk(3'd4, 16'd6, 16'd6, 0, 16'd6, 0, 0);
    tbl[8]  = mk(3'd6, 16'd32, 16'd48, 0, 16'd6, 0, 0);
    tbl[9]  = mk(3'd0, -16'sd20000, -16'sd20000, 0, 16'h8000, 1, 0);
    tbl[10] = mk(3'd6, 16'd16, 16'd16, 1, 16'd7, 0, 0);
    tbl[11] = mk(3'd6, 16'd16, 16'd16, 0, 16'd1, 0, 0);
    tbl[12] = mk(3'd2, -16'sd3, 16'h0080, 0, 16'hffff, 0, 0);
    tbl[13] = mk(3'd6, 16'd16, 16'd16, 1, 16'd2, 0, 0);

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", 32'(m_valid), 0);
    chk("rst_tready", 32'(s_ready), 0);
    chk("rst_tdata", m_data, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rdy_fix = '1;
    @(negedge clk);
    chk("post_rst_tready", 32'(s_ready), 0);
    chk("post_rst_tvalid", 32'(m_valid), 0);
    @(posedge clk);
    #1;

    // T1: latency 3, 16 back-to-back beats
    for (int i = 0; i < 16; i++)
      send(0, mk(3'd0, 16'(100 + i), -16'sd30, 0, 16'(70 + i), 0, 0), 1);
    idle(0);
    drain();

    // T2: saturation
    send(0, mk(3'd0, 16'd32767, 16'd1, 0, 16'd32767, 1, 0), 0);
    send(0, mk(3'd1, 16'h8000, 16'd1, 0, 16'h8000, 1, 0), 0);
    send(0, mk(3'd3, 16'h8000, 16'd0, 0, 16'd32767, 1, 0), 0);
    send(0, mk(3'd5, 16'd9, 16'd9, 0, 16'd9, 0, 0), 0);
    // T3: MUL with FRAC_SHIFT=8, round half up
    send(0, mk(3'd2, 16'h0180, 16'h0100, 0, 16'h0180, 0, 0), 0);
    send(0, mk(3'd2, 16'd3, 16'h0080, 0, 16'd2, 0, 0), 0);
    send(0, mk(3'd2, -16'sd3, 16'h0080, 0, 16'hffff, 0, 0), 0);
    send(0, mk(3'd2, 16'h7fff, 16'h7fff, 0, 16'd32767, 1, 0), 0);
    send(0, mk(3'd2, 16'h8000, 16'h7fff, 0, 16'h8000, 1, 0), 0);
    // T4: MAC chain restarts after tlast
    send(0, mk(3'd6, 16'd32, 16'd48, 0, 16'd6, 0, 0), 0);
    send(0, mk(3'd6, 16'd64, 16'd80, 0, 16'd26, 0, 0), 0);
    send(0, mk(3'd6, 16'd16, 16'd16, 1, 16'd27, 0, 0), 0);
    send(0, mk(3'd6, 16'd112, 16'd112, 0, 16'd49, 0, 0), 0);
    send(0, mk(3'd6, 16'd16, 16'd16, 1, 16'd50, 0, 0), 0);
    idle(0);
    drain();

    // T5: two channels, random backpressure
    rnd_mode = 1'b1;
    fork
      begin
        for (int i = 0; i < 14; i++) send(0, tbl[i], 0);
        idle(0);
      end
      begin
        for (int i = 0; i < 14; i++) send(1, tbl[i], 0);
        idle(1);
      end
    join
    drain();
    rnd_mode = 1'b0;

    // T6: reset drops in-flight beats and clears acc
    send(0, mk(3'd6, 16'd80, 16'd160, 0, 16'd50, 0, 0), 0);
    idle(0);
    drain();
    rdy_fix = '0;
    @(posedge clk);
    #1;
    send(0, mk(3'd0, 16'd1, 16'd1, 0, 16'd2, 0, 0), 0);
    send(0, mk(3'd0, 16'd2, 16'd2, 0, 16'd4, 0, 0), 0);
    idle(0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    q0.delete();
    q1.delete();
    @(negedge clk);
    chk("t6_rst_tvalid", 32'(m_valid), 0);
    chk("t6_rst_tready", 32'(s_ready), 0);
    chk("t6_rst_tdata", m_data, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rdy_fix = '1;
    @(negedge clk);
    chk("t6_post_tready", 32'(s_ready), 0);
    chk("t6_post_tvalid", 32'(m_valid), 0);
    @(posedge clk);
    #1;
    send(0, mk(3'd6, 16'd16, 16'd16, 1, 16'd1, 0, 0), 0);
    idle(0);
    drain();
    repeat (5) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
